des_fanout: RTL and testbench

DES_FANOUT -- requirements
Module: des_fanout

---
 rtl/des_fanout.sv | 166 ++++++++++++++++
 tb/tb_des_fanout.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_fanout.sv
// Gate fan-out engine: reads a gate's [begin,end) slice of the neighbor array and emits one child task per neighbor word.
// Optional statistics counters are built only when DES_FANOUT_STATS_EN is defined.
module des_fanout #(
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        task_in_valid,
  output logic        task_in_ready,
  input  logic [31:0] in_ts,
  input  logic [31:0] in_locale,
  input  logic [1:0]  in_val,
  input  logic [31:0] offset_base_addr,
  input  logic [31:0] neighbor_base_addr,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ts,
  output logic [31:0] out_locale,
  output logic [31:0] out_args,
  output logic        err,
  output logic [31:0] stat_tasks,
  output logic [31:0] stat_children
);

  typedef enum logic [2:0] {IDLE, OFS_REQ, OFS_RESP, NBR_REQ, NBR_RESP} state_t;

  localparam logic [31:0] LP_MAX = 32'(MAX_BURST);

  state_t      r_state, w_next;
  logic [31:0] r_ts, r_locale, r_cur, r_end;
  logic [1:0]  r_val;
  logic        r_ofs_second;
  logic [4:0]  r_n, r_beat;
  logic        r_err;

  logic [31:0] w_remain;
  logic [4:0]  w_len;
  logic        w_task_fire, w_ofs_fire, w_ar_nbr_fire, w_child_fire, w_last_beat;

  assign w_remain      = r_end - r_cur;
  assign w_len         = (w_remain > LP_MAX) ? LP_MAX[4:0] : w_remain[4:0];
  assign w_task_fire   = (r_state == IDLE) && task_in_valid;
  assign w_ofs_fire    = (r_state == OFS_RESP) && rvalid;
  assign w_ar_nbr_fire = (r_state == NBR_REQ) && arready;
  assign w_child_fire  = (r_state == NBR_RESP) && rvalid && out_ready;
  assign w_last_beat   = (r_beat == r_n - 5'd1);

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_next        = r_state;
    task_in_ready = 1'b0;
    arvalid       = 1'b0;
    araddr        = 32'd0;
    arlen         = 8'd0;
    rready        = 1'b0;
    out_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        task_in_ready = 1'b1;
        if (task_in_valid) w_next = OFS_REQ;
      end
      OFS_REQ: begin
        arvalid = 1'b1;
        araddr  = offset_base_addr + {r_locale[29:0], 2'b00};
        arlen   = 8'd1;
        if (arready) w_next = OFS_RESP;
      end
      OFS_RESP: begin
        rready = 1'b1;
        if (rvalid && r_ofs_second) w_next = (rdata > r_cur) ? NBR_REQ : IDLE;
      end
      NBR_REQ: begin
        arvalid = 1'b1;
        araddr  = neighbor_base_addr + {r_cur[29:0], 2'b00};
        arlen   = {3'b000, w_len - 5'd1};
        if (arready) w_next = NBR_RESP;
      end
      NBR_RESP: begin
        out_valid = rvalid;
        rready    = out_ready;
        if (w_child_fire && w_last_beat)
          w_next = (r_cur + 32'd1 == r_end) ? IDLE : NBR_REQ;
      end
      default: w_next = IDLE;
    endcase
    // Handshakes are held quiet for the whole reset window, not just after the first edge.
    if (!rstn) begin
      task_in_ready = 1'b0;
      arvalid       = 1'b0;
      rready        = 1'b0;
      out_valid     = 1'b0;
    end
  end

  // NOTE: only control state is reset; the task payload registers are always written before they are read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_err        <= 1'b0;
      r_ofs_second <= 1'b0;
      r_beat       <= 5'd0;
      r_n          <= 5'd0;
    end else begin
      r_state <= w_next;
      if (w_task_fire) begin
        r_ts     <= in_ts;
        r_locale <= in_locale;
        r_val    <= in_val;
      end
      if (w_ofs_fire) begin
        if (!r_ofs_second) begin
          r_cur        <= rdata;
          r_ofs_second <= 1'b1;
          if (rlast) r_err <= 1'b1;
        end else begin
          r_end        <= rdata;
          r_ofs_second <= 1'b0;
          if (!rlast || (rdata < r_cur)) r_err <= 1'b1;
        end
      end
      if (w_ar_nbr_fire) begin
        r_n    <= w_len;
        r_beat <= 5'd0;
      end
      if (w_child_fire) begin
        r_cur  <= r_cur + 32'd1;
        r_beat <= r_beat + 5'd1;
        if (rlast != w_last_beat) r_err <= 1'b1;
      end
    end
  end

  assign out_ts     = r_ts;
  assign out_locale = {1'b0, rdata[31:1]};
  assign out_args   = {29'd0, rdata[0], r_val};
  assign err        = r_err;

`ifdef DES_FANOUT_STATS_EN
  logic [31:0] r_stat_tasks, r_stat_children;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stat_tasks    <= 32'd0;
      r_stat_children <= 32'd0;
    end else begin
      if (w_task_fire)  r_stat_tasks    <= r_stat_tasks + 32'd1;
      if (w_child_fire) r_stat_children <= r_stat_children + 32'd1;
    end
  end

  assign stat_tasks    = r_stat_tasks;
  assign stat_children = r_stat_children;
`else
  assign stat_tasks    = 32'd0;
  assign stat_children = 32'd0;
`endif

endmodule

// File: tb/tb_des_fanout.sv
// Directed bench for des_fanout: the bench plays both the task source and the memory, with hand-computed expectations.
module tb_des_fanout;

`ifdef DES_FANOUT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [31:0] OB = 32'h0000_1000;
  localparam logic [31:0] NB = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        task_in_valid, task_in_ready;
  logic [31:0] in_ts, in_locale;
  logic [1:0]  in_val;
  logic [31:0] offset_base_addr, neighbor_base_addr;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        rvalid, rready, rlast;
  logic [31:0] rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_ts, out_locale, out_args;
  logic        err;
  logic [31:0] stat_tasks, stat_children;

  int n_cmp = 0;
  int n_err = 0;
  int child_cnt = 0;

  des_fanout #(.MAX_BURST(8)) dut (
    .clk(clk), .rstn(rstn),
    .task_in_valid(task_in_valid), .task_in_ready(task_in_ready),
    .in_ts(in_ts), .in_locale(in_locale), .in_val(in_val),
    .offset_base_addr(offset_base_addr), .neighbor_base_addr(neighbor_base_addr),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ts(out_ts), .out_locale(out_locale), .out_args(out_args),
    .err(err), .stat_tasks(stat_tasks), .stat_children(stat_children)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (out_valid && out_ready) child_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    check("rst_task_in_ready", task_in_ready, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_stat_tasks", stat_tasks, 0);
    check("rst_stat_children", stat_children, 0);
    rstn = 1'b1;
    step();
    check("post_rst_ready", task_in_ready, 1);
  endtask

  task automatic start_task(input logic [31:0] loc, input logic [1:0] v, input logic [31:0] ts);
    in_locale = loc;
    in_val = v;
    in_ts = ts;
    task_in_valid = 1'b1;
    check("accept_ready", task_in_ready, 1);
    step();
    task_in_valid = 1'b0;
    check("busy_not_ready", task_in_ready, 0);
  endtask

  task automatic ar_xfer(input string tag, input logic [31:0] a, input logic [7:0] l, input int hold);
    int n;
    n = 0;
    while (arvalid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_arvalid"}, arvalid, 1);
    for (int k = 0; k < hold; k++) begin
      check({tag, "_araddr_hold"}, araddr, a);
      check({tag, "_arlen_hold"}, arlen, l);
      step();
      check({tag, "_arvalid_hold"}, arvalid, 1);
    end
    check({tag, "_araddr"}, araddr, a);
    check({tag, "_arlen"}, arlen, l);
    arready = 1'b1;
    step();
    arready = 1'b0;
  endtask

  task automatic ofs_beats(input logic [31:0] b, input logic [31:0] e);
    rvalid = 1'b1;
    rdata = b;
    rlast = 1'b0;
    check("ofs_rready", rready, 1);
    check("ofs_out_valid", out_valid, 0);
    step();
    rdata = e;
    rlast = 1'b1;
    step();
    rvalid = 1'b0;
    rlast = 1'b0;
  endtask

  task automatic nbr_beat(input logic [31:0] d, input logic last, input logic [31:0] ts,
                          input logic [1:0] v, input int stall);
    logic [31:0] exp_loc, exp_args;
    int c0;
    exp_loc = {1'b0, d[31:1]};
    exp_args = {29'd0, d[0], v};
    rvalid = 1'b1;
    rdata = d;
    rlast = last;
    if (stall > 0) begin
      out_ready = 1'b0;
      c0 = child_cnt;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        check("stall_rready", rready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_locale", out_locale, exp_loc);
        check("stall_out_args", out_args, exp_args);
        step();
      end
      check("stall_no_child", child_cnt, c0);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("child_valid", out_valid, 1);
    check("child_rready", rready, 1);
    check("child_locale", out_locale, exp_loc);
    check("child_args", out_args, exp_args);
    check("child_ts", out_ts, ts);
    step();
    rvalid = 1'b0;
    rlast = 1'b0;
  endtask

  initial begin
    int c0;
    int idx;
    int len;
    rstn = 1'b0;
    task_in_valid = 1'b0;
    in_ts = '0;
    in_locale = '0;
    in_val = '0;
    offset_base_addr = OB;
    neighbor_base_addr = NB;
    arready = 1'b0;
    rvalid = 1'b0;
    rdata = '0;
    rlast = 1'b0;
    out_ready = 1'b1;
    step();
    do_reset();

    // Three-neighbor gate: offsets (10,13) at locale 5
    c0 = child_cnt;
    start_task(32'd5, 2'd1, 32'h100);
    ar_xfer("t1_ofs", OB + 32'h14, 8'd1, 0);
    ofs_beats(32'd10, 32'd13);
    ar_xfer("t1_nbr", NB + 32'h28, 8'd2, 0);
    nbr_beat(32'h14, 1'b0, 32'h100, 2'd1, 0);
    nbr_beat(32'h15, 1'b0, 32'h100, 2'd1, 0);
    nbr_beat(32'h20, 1'b1, 32'h100, 2'd1, 0);
    check("t1_ready_after", task_in_ready, 1);
    check("t1_err", err, 0);
    check("t1_children", child_cnt - c0, 3);
    check("t1_stat_tasks", stat_tasks, STATS ? 32'd1 : 32'd0);
    check("t1_stat_children", stat_children, STATS ? 32'd3 : 32'd0);

    // Empty range (7,7): back in IDLE four cycles after acceptance
    c0 = child_cnt;
    start_task(32'd1, 2'd2, 32'h1);
    check("t2_arvalid_now", arvalid, 1);
    ar_xfer("t2_ofs", OB + 32'h4, 8'd1, 0);
    ofs_beats(32'd7, 32'd7);
    check("t2_ready_4cyc", task_in_ready, 1);
    check("t2_no_nbr_read", arvalid, 0);
    check("t2_children", child_cnt - c0, 0);
    check("t2_err", err, 0);

    // Range (0,20): bursts of 8,8,4 with an output stall and an address-channel hold
    c0 = child_cnt;
    start_task(32'd2, 2'd0, 32'h200);
    ar_xfer("t3_ofs", OB + 32'h8, 8'd1, 0);
    ofs_beats(32'd0, 32'd20);
    idx = 0;
    for (int b = 0; b < 3; b++) begin
      len = (b < 2) ? 8 : 4;
      ar_xfer("t3_nbr", NB + 32'(idx * 4), 8'(len - 1), (b == 2) ? 3 : 0);
      for (int j = 0; j < len; j++) begin
        nbr_beat(32'(idx), (j == len - 1), 32'h200, 2'd0, (idx == 10) ? 5 : 0);
        idx++;
      end
    end
    check("t3_ready_after", task_in_ready, 1);
    check("t3_children", child_cnt - c0, 20);
    check("t3_err", err, 0);

    // Reversed range (9,4): error, no neighbor read, no child
    c0 = child_cnt;
    start_task(32'd3, 2'd1, 32'h3);
    ar_xfer("t4_ofs", OB + 32'hC, 8'd1, 0);
    ofs_beats(32'd9, 32'd4);
    check("t4_err", err, 1);
    check("t4_idle", task_in_ready, 1);
    check("t4_no_read", arvalid, 0);
    check("t4_children", child_cnt - c0, 0);
    do_reset();

    // Early rlast on beat 2 of 4: error, but all four children still emitted
    c0 = child_cnt;
    start_task(32'd4, 2'd3, 32'h44);
    ar_xfer("t5_ofs", OB + 32'h10, 8'd1, 0);
    ofs_beats(32'd0, 32'd4);
    ar_xfer("t5_nbr", NB, 8'd3, 0);
    nbr_beat(32'd2, 1'b0, 32'h44, 2'd3, 0);
    check("t5_err_before", err, 0);
    nbr_beat(32'd3, 1'b1, 32'h44, 2'd3, 0);
    check("t5_err_early_rlast", err, 1);
    nbr_beat(32'd4, 1'b0, 32'h44, 2'd3, 0);
    nbr_beat(32'd5, 1'b0, 32'h44, 2'd3, 0);
    check("t5_children", child_cnt - c0, 4);
    check("t5_idle", task_in_ready, 1);
    do_reset();

    // Reset in the middle of a neighbor burst
    c0 = child_cnt;
    start_task(32'd6, 2'd1, 32'h66);
    ar_xfer("t6_ofs", OB + 32'h18, 8'd1, 0);
    ofs_beats(32'd0, 32'd4);
    ar_xfer("t6_nbr", NB, 8'd3, 0);
    nbr_beat(32'd8, 1'b0, 32'h66, 2'd1, 0);
    rvalid = 1'b1;
    rdata = 32'd9;
    rstn = 1'b0;
    step();
    check("t6_out_valid_rst", out_valid, 0);
    check("t6_rready_rst", rready, 0);
    check("t6_ready_rst", task_in_ready, 0);
    check("t6_stat_tasks", stat_tasks, 0);
    check("t6_stat_children", stat_children, 0);
    rstn = 1'b1;
    step();
    check("t6_idle", task_in_ready, 1);
    check("t6_out_valid_after", out_valid, 0);
    rvalid = 1'b0;
    step();
    check("t6_children", child_cnt - c0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
